// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32 subset control sequencer:
// legal major opcodes and the sequencer state encoding.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } ctrl_state_t;

  // True when the major opcode belongs to the supported subset.
  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter shared by the instruction-fetch and data-access
// phases. The counter is cleared whenever the sequencer changes state and
// advances once per cycle spent waiting for a ready. o_expire flags the
// last allowed wait cycle: a cycle with no ready while o_expire is high
// would take the count to MEM_TIMEOUT, so the sequencer halts instead.
module mem_wait_timer import core_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_cnt;

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = (r_cnt == LP_LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the lab RV32 subset core.
// Fetches into an instruction register, steps EXEC/MEM/WB phases, owns the
// PC, and halts (sticky until reset) on an illegal opcode or memory timeout.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds cycle_cnt and
// instret_cnt performance counters.
//
// state  | meaning
// FETCH  | request instruction at pc, latch it on imem_ready
// DECODE | one cycle for the decoder to settle, opcode legality check
// EXEC   | resolve branch / pick MEM or WB by decoder class flags
// MEM    | data access, store completes here
// WB     | one-cycle register-file write strobe, pc += 4
// HALT   | sticky stop, all strobes low
module multicycle_ctrl import core_pkg::*; #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        load,
  input  logic        store,
  input  logic        br_eq,
  input  logic        br_nq,
  input  logic [31:0] imm,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halt
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic        r_run;
  logic        r_is_store;

  logic        w_instr_ld;
  logic        w_cls_ld;
  logic        w_wait_count;
  logic        w_wait_clear;
  logic        w_expire;
  logic        w_taken;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_branch;
  logic [31:0] w_imm_x2;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_imm_x2    = imm << 1;
  assign w_pc_branch = r_pc + w_imm_x2;
  assign w_taken     = (br_eq & alu_zero) | (br_nq & ~alu_zero);

  // Any state change restarts the wait count, so FETCH and MEM each begin
  // with a fresh budget.
  assign w_wait_clear = (w_state_nxt != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_wait_clear),
    .i_count (w_wait_count),
    .o_expire(w_expire)
  );

  // Next-state, next-PC and load-enable decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_ld   = 1'b0;
    w_cls_ld     = 1'b0;
    w_wait_count = 1'b0;
    case (r_state)
      ST_FETCH: begin
        // r_run holds the request off for the first cycle after reset
        // release; ready outside a request is ignored.
        if (r_run) begin
          if (imem_ready) begin
            w_state_nxt = ST_DECODE;
            w_instr_ld  = 1'b1;
          end else if (w_expire) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_wait_count = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        w_state_nxt = opcode_legal(r_instr[6:0]) ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        // Class is taken from the decoder flags, which may remap opcodes.
        if (br_eq | br_nq) begin
          w_pc_nxt    = w_taken ? w_pc_branch : w_pc_plus4;
          w_state_nxt = ST_FETCH;
        end else if (load | store) begin
          w_cls_ld    = 1'b1;
          w_state_nxt = ST_MEM;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (r_is_store) begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WB;
          end
        end else if (w_expire) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_wait_count = 1'b1;
        end
      end
      ST_WB: begin
        w_pc_nxt    = w_pc_plus4;
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, instruction register, store-class latch and fetch enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= PC_RESET;
      r_instr    <= 32'd0;
      r_run      <= 1'b0;
      r_is_store <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_run <= 1'b1;
      if (w_instr_ld) begin
        r_instr <= imem_rdata;
      end
      if (w_cls_ld) begin
        r_is_store <= store;
      end
    end
  end

  assign imem_req  = (r_state == ST_FETCH) & r_run;
  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign dmem_req  = (r_state == ST_MEM);
  assign dmem_we   = (r_state == ST_MEM) & r_is_store;
  assign rf_we     = (r_state == ST_WB);
  assign pc        = r_pc;
  assign state     = r_state;
  assign halt      = (r_state == ST_HALT);

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic        w_retire;

  assign w_retire = ((r_state == ST_EXEC) || (r_state == ST_MEM) ||
                     (r_state == ST_WB)) && (w_state_nxt == ST_FETCH);

  // Free-running cycle and retired-instruction counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if (r_state != ST_HALT) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_retire) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of instructions with
// hand-computed latency, PC and strobe counts, plus hand-written sequences
// for illegal opcode, fetch timeout and reset during a store.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        load, store, br_eq, br_nq;
  logic [31:0] imm;
  logic        alu_zero;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halt;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  multicycle_ctrl #(
    .PC_RESET   (32'h0000_0000),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .load       (load),
    .store      (store),
    .br_eq      (br_eq),
    .br_nq      (br_nq),
    .imm        (imm),
    .alu_zero   (alu_zero),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .rf_we      (rf_we),
    .pc         (pc),
    .state      (state),
    .halt       (halt)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ld, st, beq, bne;
    logic [31:0] imm;
    logic        az;
    int          iw, dw;
    int          cyc;
    logic [31:0] pc;
    int          rf, dq, dwe;
    logic [23:0] trace;
  } vec_t;

  vec_t vec[14];

  int tests = 0;
  int fails = 0;

  int          m_cyc, m_rf, m_dq, m_dwe;
  logic [31:0] m_faddr;
  logic [23:0] m_trace;
  logic [2:0]  m_end;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BNE  = 32'h00001063;

  function automatic vec_t mk(input logic [31:0] rdata, input logic ld, st, beq, bne,
                              input logic [31:0] im, input logic az, input int iw, dw, cyc,
                              input logic [31:0] epc, input int rf, dq, dwe,
                              input logic [23:0] trace);
    vec_t v;
    v.rdata = rdata; v.ld = ld; v.st = st; v.beq = beq; v.bne = bne;
    v.imm = im; v.az = az; v.iw = iw; v.dw = dw; v.cyc = cyc;
    v.pc = epc; v.rf = rf; v.dq = dq; v.dwe = dwe; v.trace = trace;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one instruction from its first request cycle until the sequencer
  // re-enters FETCH or halts. Called at a negedge; returns at a negedge.
  task automatic do_instr(input vec_t v);
    int iwc, dwc, guard;
    logic [2:0] prev;
    imem_rdata = v.rdata; load = v.ld; store = v.st;
    br_eq = v.beq; br_nq = v.bne; imm = v.imm; alu_zero = v.az;
    m_cyc = 0; m_rf = 0; m_dq = 0; m_dwe = 0; m_trace = '0;
    iwc = 0; dwc = 0; guard = 0;
    while (!imem_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    m_faddr = imem_addr;
    while (m_cyc < 64) begin
      prev = state;
      m_trace = {m_trace[20:0], state};
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (imem_req) begin
        if (iwc == v.iw) imem_ready = 1'b1;
        else iwc++;
      end
      if (dmem_req) begin
        m_dq++;
        if (dmem_we) m_dwe++;
        if (dwc == v.dw) dmem_ready = 1'b1;
        else dwc++;
      end
      if (rf_we) m_rf++;
      m_cyc++;
      @(negedge clk);
      if ((state == 3'd0 && prev != 3'd0) || state == 3'd7) break;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    m_end = state;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    logic [31:0] exp_faddr;

    vec[0]  = mk(I_ADD,  0,0,0,0, 32'h0,        0, 0,0, 4, 32'h0000_0004, 1,0,0, 24'o124);
    vec[1]  = mk(I_ADDI, 0,0,0,0, 32'h1,        0, 2,0, 6, 32'h0000_0008, 1,0,0, 24'o124);
    vec[2]  = mk(I_LW,   1,0,0,0, 32'h0,        0, 0,3, 8, 32'h0000_000C, 1,4,0, 24'o01233334);
    vec[3]  = mk(I_SW,   0,1,0,0, 32'h0,        0, 0,0, 4, 32'h0000_0010, 0,1,1, 24'o123);
    vec[4]  = mk(I_SW,   0,1,0,0, 32'h0,        0, 0,2, 6, 32'h0000_0014, 0,3,3, 24'o12333);
    vec[5]  = mk(I_BEQ,  0,0,1,0, 32'h76,       1, 0,0, 3, 32'h0000_0100, 0,0,0, 24'o12);
    vec[6]  = mk(I_BEQ,  0,0,1,0, 32'h8,        1, 0,0, 3, 32'h0000_0110, 0,0,0, 24'o12);
    vec[7]  = mk(I_BNE,  0,0,0,1, 32'hFFFFFFF8, 0, 0,0, 3, 32'h0000_0100, 0,0,0, 24'o12);
    vec[8]  = mk(I_BEQ,  0,0,1,0, 32'h8,        0, 0,0, 3, 32'h0000_0104, 0,0,0, 24'o12);
    vec[9]  = mk(I_BNE,  0,0,0,1, 32'hFFFFFFFE, 0, 0,0, 3, 32'h0000_0100, 0,0,0, 24'o12);
    vec[10] = mk(I_BNE,  0,0,0,1, 32'h8,        0, 0,0, 3, 32'h0000_0110, 0,0,0, 24'o12);
    vec[11] = mk(I_BNE,  0,0,0,1, 32'h8,        1, 0,0, 3, 32'h0000_0114, 0,0,0, 24'o12);
    vec[12] = mk(I_BEQ,  0,0,1,0, 32'hFFFFFF74, 1, 0,0, 3, 32'hFFFF_FFFC, 0,0,0, 24'o12);
    vec[13] = mk(I_ADD,  0,0,0,0, 32'h0,        0, 1,0, 5, 32'h0000_0000, 1,0,0, 24'o124);

    rst_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    load = 1'b0; store = 1'b0; br_eq = 1'b0; br_nq = 1'b0;
    imm = 32'h0; alu_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("rst state", {29'd0, state}, 32'd0);
    chk("rst pc", pc, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
    chk("rst halt", {31'd0, halt}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("rst cycle_cnt", cycle_cnt, 32'd0);
    chk("rst instret_cnt", instret_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("first req after release", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      exp_faddr = (i == 0) ? 32'h0 : vec[i-1].pc;
      do_instr(vec[i]);
      chk($sformatf("v%0d fetch addr", i), m_faddr, exp_faddr);
      chk($sformatf("v%0d cycles", i), m_cyc, vec[i].cyc);
      chk($sformatf("v%0d trace", i), {8'd0, m_trace}, {8'd0, vec[i].trace});
      chk($sformatf("v%0d end state", i), {29'd0, m_end}, 32'd0);
      chk($sformatf("v%0d pc", i), pc, vec[i].pc);
      chk($sformatf("v%0d instr", i), instr, vec[i].rdata);
      chk($sformatf("v%0d rf_we cycles", i), m_rf, vec[i].rf);
      chk($sformatf("v%0d dmem_req cycles", i), m_dq, vec[i].dq);
      chk($sformatf("v%0d dmem_we cycles", i), m_dwe, vec[i].dwe);
    end

    // Illegal opcode: FETCH, DECODE, then sticky HALT.
    do_instr(mk(32'h0000_007F, 0,0,0,0, 32'h0, 0, 0,0, 2, 32'h0, 0,0,0, 24'o1));
    chk("illegal cycles", m_cyc, 2);
    chk("illegal end state", {29'd0, m_end}, 32'd7);
    chk("illegal no strobes", m_rf + m_dq, 0);
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("halt hold %0d", k), {27'd0, state, halt, imem_req, dmem_req, rf_we},
          {27'd0, 3'd7, 4'b1000});
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    chk("halt pc", pc, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("halt reset", {27'd0, state, halt, imem_req, dmem_req, rf_we}, 32'd0);
    chk("halt reset pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch timeout: imem_ready never comes.
    guard = 0;
    while (!imem_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout req cycles", n, 16);
    chk("timeout state", {29'd0, state}, 32'd7);
    chk("timeout halt", {31'd0, halt}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Ready on the last allowed wait cycle wins over the timeout.
    do_instr(mk(I_ADD, 0,0,0,0, 32'h0, 0, 15,0, 19, 32'h4, 1,0,0, 24'o124));
    chk("ready at timeout cycles", m_cyc, 19);
    chk("ready at timeout end", {29'd0, m_end}, 32'd0);
    chk("ready at timeout pc", pc, 32'h4);
    chk("ready at timeout rf", m_rf, 1);

    // Reset asserted mid-MEM store.
    imem_rdata = I_SW; load = 1'b0; store = 1'b1; br_eq = 1'b0; br_nq = 1'b0;
    guard = 0;
    while (!imem_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    guard = 0;
    while (state != 3'd3 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("mid store dmem_req", {30'd0, dmem_req, dmem_we}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid store async drop", {28'd0, dmem_req, dmem_we, imem_req, rf_we}, 32'd0);
    chk("mid store state", {29'd0, state}, 32'd0);
    chk("mid store pc", pc, 32'h0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("mid store cycle_cnt", cycle_cnt, 32'd0);
    chk("mid store instret_cnt", instret_cnt, 32'd0);
`endif
    dmem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("late dmem_ready %0d", k), {28'd0, state, dmem_req}, 32'd0);
    end
    chk("restart pc", pc, 32'h0);
    chk("restart instr", instr, 32'h0);
    dmem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
